conv_arbiter: RTL and testbench

- Shares one single-precision int-to-float converter between N independent requesters, each using stb/ack handshakes.
- Round-robin arbiter: accepts one request, issues it to the converter, collects the result and returns it to the originating requester.
- Exactly one transaction is in flight at a time.
- Sits between client blocks and the converter instance; the converter connects directly to the conv_* ports.

---
 rtl/conv_arbiter.sv | 156 +++++++++++++++
 tb/tb_conv_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_arbiter.sv
// Round-robin arbiter sharing one int-to-float converter among N stb/ack requesters.
// Define ARB_TIMEOUT_EN to add a converter watchdog that aborts a stalled transaction.
module conv_arbiter #(
    parameter int N       = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*32-1:0]   req_a,
    input  logic [N-1:0]      req_a_stb,
    output logic [N-1:0]      req_a_ack,
    output logic [31:0]       rsp_z,
    output logic [N-1:0]      rsp_z_stb,
    input  logic [N-1:0]      rsp_z_ack,
    output logic              timeout_err,
    output logic [31:0]       conv_a,
    output logic              conv_a_stb,
    input  logic              conv_a_ack,
    input  logic [31:0]       conv_z,
    input  logic              conv_z_stb,
    output logic              conv_z_ack
);

    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, RETURN} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] grant, rr_ptr, winner;
    logic             xfer_a, xfer_z, rsp_done, expired;

    // First requesting lane at or after ptr, wrapping modulo N.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] stb,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && stb[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign winner   = rr_pick(req_a_stb, rr_ptr);
    assign xfer_a   = conv_a_stb && conv_a_ack;
    assign xfer_z   = conv_z_stb && conv_z_ack;
    assign rsp_done = rsp_z_ack[grant];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // Saturates at the limit so a handshake landing on the expiry cycle cannot wrap it.
    assign expired = (cnt >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ACCEPT)
                cnt <= '0;
            else if ((state == ISSUE || state == WAIT) && !expired)
                cnt <= cnt + 1'b1;

            if (expired && ((state == ISSUE && !xfer_a) || (state == WAIT && !xfer_z)))
                timeout_err <= 1'b1;
            else if (state == RETURN && rsp_done)
                timeout_err <= 1'b0;
        end
    end
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_a_stb) state_nxt = ACCEPT;
            ACCEPT:  state_nxt = ISSUE;
            ISSUE:   if (xfer_a) state_nxt = WAIT;
                     else if (expired) state_nxt = RETURN;
            WAIT:    if (xfer_z || expired) state_nxt = RETURN;
            RETURN:  if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // conv_a doubles as the operand register and rsp_z as the result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= '0;
            rr_ptr     <= '0;
            req_a_ack  <= '0;
            conv_a     <= '0;
            conv_a_stb <= 1'b0;
            conv_z_ack <= 1'b0;
            rsp_z      <= '0;
            rsp_z_stb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_a_stb) begin
                        grant     <= winner;
                        req_a_ack <= N'(1) << winner;
                    end
                end
                ACCEPT: begin
                    conv_a     <= req_a[32*grant +: 32];
                    req_a_ack  <= '0;
                    conv_a_stb <= 1'b1;
                end
                ISSUE: begin
                    if (xfer_a) begin
                        conv_a_stb <= 1'b0;
                        conv_z_ack <= 1'b1;
                    end else if (expired) begin
                        conv_a_stb <= 1'b0;
                        rsp_z      <= '0;
                        rsp_z_stb  <= N'(1) << grant;
                    end
                end
                WAIT: begin
                    if (xfer_z) begin
                        conv_z_ack <= 1'b0;
                        rsp_z      <= conv_z;
                        rsp_z_stb  <= N'(1) << grant;
                    end else if (expired) begin
                        conv_z_ack <= 1'b0;
                        rsp_z      <= '0;
                        rsp_z_stb  <= N'(1) << grant;
                    end
                end
                RETURN: begin
                    if (rsp_done) begin
                        rsp_z_stb <= '0;
                        rr_ptr    <= (grant == IDX_W'(N - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_arbiter.sv
// Scoreboard bench for conv_arbiter with a behavioural int-to-float converter attached.
// The watchdog scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_conv_arbiter;

    localparam int N       = 4;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*32-1:0] req_a;
    logic [N-1:0]    req_a_stb, req_a_ack;
    logic [31:0]     rsp_z;
    logic [N-1:0]    rsp_z_stb, rsp_z_ack, rsp_ack_mon, rsp_ack_extra;
    logic            timeout_err;
    logic [31:0]     conv_a, conv_z;
    logic            conv_a_stb, conv_a_ack, conv_z_stb, conv_z_ack;

    assign rsp_z_ack = rsp_ack_mon | rsp_ack_extra;

    conv_arbiter #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
        .rsp_z(rsp_z), .rsp_z_stb(rsp_z_stb), .rsp_z_ack(rsp_z_ack),
        .timeout_err(timeout_err),
        .conv_a(conv_a), .conv_a_stb(conv_a_stb), .conv_a_ack(conv_a_ack),
        .conv_z(conv_z), .conv_z_stb(conv_z_stb), .conv_z_ack(conv_z_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        logic [31:0] z;
        logic        terr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Round-to-nearest-even signed int32 to IEEE single.
    function automatic logic [31:0] int2float(input logic [31:0] a);
        logic [31:0] mag, mant, rem, half;
        logic [7:0]  e;
        logic        s;
        int          p, sh;
        if (a == 32'h0) return 32'h0;
        s   = a[31];
        mag = s ? (~a + 32'd1) : a;
        p   = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        e = 8'(p + 127);
        if (p <= 23) begin
            mant = mag << (23 - p);
        end else begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                e    = e + 8'd1;
            end
        end
        return {s, e, mant[22:0]};
    endfunction

    // Converter model: accepts when idle, answers cv_lat+1 cycles later; stuck mode drops operands.
    logic        cv_busy, cv_stuck;
    logic [31:0] cv_res;
    int          cv_lat, cv_cnt;

    assign conv_a_ack = rst && !cv_busy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cv_busy    <= 1'b0;
            conv_z_stb <= 1'b0;
            conv_z     <= 32'h0;
            cv_cnt     <= 0;
        end else begin
            if (conv_a_stb && conv_a_ack) begin
                if (!cv_stuck) begin
                    cv_busy <= 1'b1;
                    cv_res  <= int2float(conv_a);
                    cv_cnt  <= cv_lat;
                end
            end else if (cv_busy && !conv_z_stb) begin
                if (cv_cnt == 0) begin
                    conv_z_stb <= 1'b1;
                    conv_z     <= cv_res;
                end else begin
                    cv_cnt <= cv_cnt - 1;
                end
            end
            if (conv_z_stb && conv_z_ack) begin
                conv_z_stb <= 1'b0;
                cv_busy    <= 1'b0;
            end
        end
    end

    task automatic expect_rsp(input int lane, input logic [31:0] z, input logic terr);
        exp_t x;
        x.lane = lane;
        x.z    = z;
        x.terr = terr;
        sb_q.push_back(x);
    endtask

    task automatic send(input int lane, input logic [31:0] val, output int lat);
        @(negedge clk);
        req_a[32*lane +: 32] = val;
        req_a_stb[lane]      = 1'b1;
        lat = 0;
        while (!req_a_ack[lane] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!req_a_ack[lane]) begin
            check("ack_wait", 32'(req_a_ack[lane]), 32'h1);
            req_a_stb[lane] = 1'b0;
            return;
        end
        check("ack_onehot", 32'(req_a_ack), 32'(1) << lane);
        @(posedge clk);
        #1 req_a_stb[lane] = 1'b0;
        @(negedge clk);
        check("ack_pulse", 32'(req_a_ack[lane]), 32'h0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || rsp_z_stb != '0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_q", 32'(sb_q.size()), 32'h0);
    endtask

    // Response side: compare against the scoreboard, hold two cycles, then ack.
    initial begin
        exp_t x;
        rsp_ack_mon = '0;
        forever begin
            @(negedge clk);
            if (rst && rsp_z_stb != '0) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_z_stb), 32'h0);
                end else begin
                    x = sb_q.pop_front();
                    check("rsp_lane", 32'(rsp_z_stb), 32'(1) << x.lane);
                    check("rsp_z", rsp_z, x.z);
                    check("rsp_terr", 32'(timeout_err), 32'(x.terr));
                    repeat (2) begin
                        @(negedge clk);
                        check("rsp_hold", 32'(rsp_z_stb), 32'(1) << x.lane);
                    end
                end
                rsp_ack_mon = rsp_z_stb;
                @(posedge clk);
                #1 rsp_ack_mon = '0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed running expected finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int lat, l0, l1, l2, l3, n, ln;
        logic [31:0] v;
        rst = 1'b1; req_a = '0; req_a_stb = '0; rsp_ack_extra = '0;
        cv_lat = 2; cv_stuck = 1'b0;
        #3 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_ctl", 32'({req_a_ack, rsp_z_stb, conv_a_stb, conv_z_ack, timeout_err}), 32'h0);
        check("rst_rsp_z", rsp_z, 32'h0);
        check("rst_conv_a", conv_a, 32'h0);
        rst = 1'b1;

        // Single request on lane 0.
        expect_rsp(0, 32'h3F800000, 1'b0);
        send(0, 32'h00000001, lat);
        check("ack_latency", 32'(lat), 32'd1);
        drain();

        // Back-to-back on lane 2.
        expect_rsp(2, 32'hBF800000, 1'b0);
        expect_rsp(2, 32'h00000000, 1'b0);
        send(2, 32'hFFFFFFFF, lat);
        send(2, 32'h00000000, lat);
        drain();

        // All lanes at once from reset: service order 0,1,2,3.
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        expect_rsp(0, 32'h3F800000, 1'b0);
        expect_rsp(1, 32'h40000000, 1'b0);
        expect_rsp(2, 32'h40400000, 1'b0);
        expect_rsp(3, 32'h4B800000, 1'b0);
        fork
            send(0, 32'd1, l0);
            send(1, 32'd2, l1);
            send(2, 32'd3, l2);
            send(3, 32'd16777217, l3);
        join
        check("sim_ack_latency", 32'(l0), 32'd1);
        drain();

        // Lane 1 served, then 0 and 1 together: lane 0 wins; stray ack on lane 3.
        expect_rsp(1, 32'h40A00000, 1'b0);
        send(1, 32'd5, lat);
        drain();
        rsp_ack_extra[3] = 1'b1;
        expect_rsp(0, 32'h40E00000, 1'b0);
        expect_rsp(1, 32'h42C80000, 1'b0);
        fork
            send(0, 32'd7, l0);
            send(1, 32'd100, l1);
        join
        drain();
        rsp_ack_extra = '0;

        // Most negative operand and a short random burst.
        expect_rsp(3, 32'hCF000000, 1'b0);
        send(3, 32'h80000000, lat);
        for (int i = 0; i < 6; i++) begin
            ln = $urandom_range(0, N - 1);
            v  = $urandom;
            expect_rsp(ln, int2float(v), 1'b0);
            send(ln, v, lat);
        end
        drain();

        // Asynchronous reset while waiting on a slow converter.
        cv_lat = 20;
        send(0, 32'd9, lat);
        n = 0;
        while (!conv_z_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait", 32'(conv_z_ack), 32'h1);
        rst = 1'b0;
        #1;
        check("async_ctl", 32'({req_a_ack, rsp_z_stb, conv_a_stb, conv_z_ack, timeout_err}), 32'h0);
        check("async_rsp_z", rsp_z, 32'h0);
        check("async_conv_a", conv_a, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cv_lat = 2;
        sb_q.delete();
        expect_rsp(0, 32'h40000000, 1'b0);
        send(0, 32'd2, lat);
        drain();

`ifdef ARB_TIMEOUT_EN
        // Converter never answers: abort after TIMEOUT cycles, then recover.
        cv_stuck = 1'b1;
        expect_rsp(1, 32'h00000000, 1'b1);
        send(1, 32'd5, lat);
        n = 0;
        while (!rsp_z_stb[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd8);
        drain();
        cv_stuck = 1'b0;
        expect_rsp(2, 32'h40400000, 1'b0);
        send(2, 32'd3, lat);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
